// File: rtl/hazard_unit_if.sv
// Pipeline-side bundle for the hazard unit: ID-stage operand/control info in,
// stall/bubble/forwarding decisions and the stall counter out.
interface hazard_unit_if;
    logic [4:0]  id_rn;
    logic [4:0]  id_rm;
    logic [4:0]  id_rd;
    logic        id_useRn;
    logic        id_useRm;
    logic        id_RegWrite;
    logic        id_MemRead;
    logic        flush;
    logic        stall;
    logic        bubble;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic [15:0] stallCount;

    modport master (
        output id_rn, id_rm, id_rd, id_useRn, id_useRm, id_RegWrite, id_MemRead, flush,
        input  stall, bubble, fwdA, fwdB, stallCount
    );

    modport slave (
        input  id_rn, id_rm, id_rd, id_useRn, id_useRm, id_RegWrite, id_MemRead, flush,
        output stall, bubble, fwdA, fwdB, stallCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline.
// Define HAZARD_FWD_EN for EX forwarding with load-use stalls; otherwise stall on any EX/MEM dependency.
module hazard_unit (
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  hz
);
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       use_rn;
        logic       use_rm;
    } trk_t;

    localparam trk_t       TRK_EMPTY = {$bits(trk_t){1'b0}};
    localparam logic [4:0] XZR       = 5'd31;

    // XZR never carries a dependency, and an unused source never creates one.
    function automatic logic match_f(input trk_t stg, input logic [4:0] src, input logic use_bit);
        match_f = stg.reg_write & use_bit & (src != XZR) & (stg.rd == src);
    endfunction

    trk_t        id_s;
    trk_t        ex_r;
    trk_t        mem_r;
    trk_t        wb_r;
    logic        hazard_s;
    logic        stall_s;
    logic        bubble_s;
    logic [1:0]  fwd_a_s;
    logic [1:0]  fwd_b_s;
    logic [15:0] stall_count_r;
    logic        unused_wb_s;

    // Pack the ID-stage fields in tracker layout.
    always_comb begin
        id_s = {hz.id_rd, hz.id_RegWrite, hz.id_MemRead, hz.id_rn, hz.id_rm, hz.id_useRn, hz.id_useRm};
    end

`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be forwarded in time for the ID consumer.
    always_comb begin
        hazard_s = ex_r.mem_read & (match_f(ex_r, hz.id_rn, hz.id_useRn) |
                                    match_f(ex_r, hz.id_rm, hz.id_useRm));
    end

    // Operand select for the instruction in EX; the younger MEM result wins over WB.
    always_comb begin
        if (match_f(mem_r, ex_r.rn, ex_r.use_rn)) begin
            fwd_a_s = 2'b10;
        end else if (match_f(wb_r, ex_r.rn, ex_r.use_rn)) begin
            fwd_a_s = 2'b01;
        end else begin
            fwd_a_s = 2'b00;
        end
        if (match_f(mem_r, ex_r.rm, ex_r.use_rm)) begin
            fwd_b_s = 2'b10;
        end else if (match_f(wb_r, ex_r.rm, ex_r.use_rm)) begin
            fwd_b_s = 2'b01;
        end else begin
            fwd_b_s = 2'b00;
        end
    end
`else
    // Without forwarding, any producer still in EX or MEM blocks the consumer.
    always_comb begin
        hazard_s = match_f(ex_r,  hz.id_rn, hz.id_useRn) | match_f(ex_r,  hz.id_rm, hz.id_useRm) |
                   match_f(mem_r, hz.id_rn, hz.id_useRn) | match_f(mem_r, hz.id_rm, hz.id_useRm);
    end

    // Operands always come from the register file.
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
    end
`endif

    // Flush beats any hazard; reset low silences both controls.
    always_comb begin
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        if (!reset) begin
            stall_s  = 1'b0;
            bubble_s = 1'b0;
        end else if (hz.flush) begin
            stall_s  = 1'b0;
            bubble_s = 1'b1;
        end else if (hazard_s) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
        end else begin
            stall_s  = 1'b0;
            bubble_s = 1'b0;
        end
    end

    // Tracker pipeline moving in lockstep with the control pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_r  <= TRK_EMPTY;
            mem_r <= TRK_EMPTY;
            wb_r  <= TRK_EMPTY;
        end else begin
            ex_r  <= bubble_s ? TRK_EMPTY : id_s;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_r <= 16'd0;
        end else if (stall_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    // WB fields beyond rd/RegWrite exist for pipeline visibility only.
    assign unused_wb_s = ^wb_r;

    assign hz.stall      = stall_s;
    assign hz.bubble     = bubble_s;
    assign hz.fwdA       = fwd_a_s;
    assign hz.fwdB       = fwd_b_s;
    assign hz.stallCount = stall_count_r;
endmodule
